inst_fetch_queue: RTL and testbench

Dual-issue instruction queue that consumes the PC unit's fetch stream and feeds decode. Each cycle it accepts 0-2 fetched instructions (pc, pc+4) from the instruction-memory return path, and delivers 0-2 instructions in program order to decode. It generates hold_pc back to the PC unit for back-pressure, and clears on flush (jump or exception).

---
 rtl/inst_fetch_queue_pkg.sv | 20 ++
 rtl/inst_fetch_queue.sv | 152 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU front-end types and queue sizing constants.
//   InstAddr_t   : 32-bit instruction address
//   Inst_t       : 32-bit instruction word
//   FetchEntry_t : one queued instruction {pc, inst}
//   IFQ_DEPTH, IFQ_HOLD_MARGIN : default queue sizing, shared with the PC unit wiring
package inst_fetch_queue_pkg;

  typedef logic [31:0] InstAddr_t;
  typedef logic [31:0] Inst_t;

  typedef struct packed {
    InstAddr_t pc;
    Inst_t     inst;
  } FetchEntry_t;

  localparam int IFQ_DEPTH       = 8;
  // One fetch pair already in flight plus the pair arriving this cycle.
  localparam int IFQ_HOLD_MARGIN = 4;

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between the fetch return path and decode.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop all entries and the current write (redirect)
//   fetch_valid         : fetch pair present this cycle
//   fetch_pc            : address of fetch_inst1 (fetch_inst2 lives at +4)
//   fetch_inst1/2       : fetched instruction words
//   fetch_inst2_valid   : second word usable
//   issue_cnt           : entries decode consumes this cycle (0..2, 3 clamps)
//   out0_* / out1_*     : head and head+1 entries presented to decode
//   hold_pc             : stall request to the PC unit
//   overflow            : sticky flag, a fetch pair was dropped for lack of space
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH       = IFQ_DEPTH,
  parameter int HOLD_MARGIN = IFQ_HOLD_MARGIN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst1,
  input  logic [31:0] fetch_inst2,
  input  logic        fetch_inst2_valid,
  input  logic [1:0]  issue_cnt,
  output logic        out0_valid,
  output logic [31:0] out0_pc,
  output logic [31:0] out0_inst,
  output logic        out1_valid,
  output logic [31:0] out1_pc,
  output logic [31:0] out1_inst,
  output logic        hold_pc,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so count - rd + wr can exceed DEPTH without wrapping.
  localparam int SUM_W = CNT_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);
  localparam logic [SUM_W-1:0] DEPTH_SUM   = SUM_W'(DEPTH);
  // hold when free entries (DEPTH - count) drop below HOLD_MARGIN.
  localparam logic [CNT_W-1:0] HOLD_THRESH = CNT_W'(DEPTH - HOLD_MARGIN);

  FetchEntry_t        mem_r [DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [CNT_W-1:0]   count_r;
  logic               overflow_r;

  logic [1:0]         wr_s;
  logic [1:0]         rd_s;
  logic [1:0]         issue_lim_s;
  logic [SUM_W-1:0]   next_cnt_s;
  logic               fits_s;
  logic [PTR_W-1:0]   head1_s;
  logic [PTR_W-1:0]   tail1_s;

  assign head1_s = head_r + PTR_ONE;
  assign tail1_s = tail_r + PTR_ONE;

  // Write/read amounts and the space check for this cycle.
  always_comb begin
    wr_s        = 2'd0;
    rd_s        = 2'd0;
    issue_lim_s = 2'd0;
    if (fetch_valid && !flush) begin
      wr_s = 2'd1 + {1'b0, fetch_inst2_valid};
    end else begin
      wr_s = 2'd0;
    end
    // Only two output slots exist, so a request of 3 consumes at most 2.
    if (issue_cnt > 2'd2) begin
      issue_lim_s = 2'd2;
    end else begin
      issue_lim_s = issue_cnt;
    end
    // Never read past what is stored.
    if (count_r < CNT_W'(issue_lim_s)) begin
      rd_s = count_r[1:0];
    end else begin
      rd_s = issue_lim_s;
    end
    next_cnt_s = {1'b0, count_r} - SUM_W'(rd_s) + SUM_W'(wr_s);
    fits_s     = (next_cnt_s <= DEPTH_SUM);
  end

  // Pointer, count and overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush) begin
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      head_r <= head_r + PTR_W'(rd_s);
      if (fits_s) begin
        tail_r  <= tail_r + PTR_W'(wr_s);
        count_r <= next_cnt_s[CNT_W-1:0];
      end else begin
        // Whole pair dropped; the read still happens.
        count_r    <= count_r - CNT_W'(rd_s);
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage: up to two writes per cycle at tail and tail+1.
  always_ff @(posedge clk) begin
    if (fits_s && (wr_s != 2'd0)) begin
      mem_r[tail_r] <= '{pc: fetch_pc, inst: fetch_inst1};
      if (wr_s == 2'd2) begin
        mem_r[tail1_s] <= '{pc: fetch_pc + 32'd4, inst: fetch_inst2};
      end
    end
  end

  // Decode-facing outputs straight from storage; data forced to zero when invalid.
  always_comb begin
    out0_valid = (count_r >= CNT_ONE);
    out1_valid = (count_r >= CNT_TWO);
    if (out0_valid) begin
      out0_pc   = mem_r[head_r].pc;
      out0_inst = mem_r[head_r].inst;
    end else begin
      out0_pc   = 32'd0;
      out0_inst = 32'd0;
    end
    if (out1_valid) begin
      out1_pc   = mem_r[head1_s].pc;
      out1_inst = mem_r[head1_s].inst;
    end else begin
      out1_pc   = 32'd0;
      out1_inst = 32'd0;
    end
  end

  // Back-pressure depends only on registered count, not on issue_cnt.
  assign hold_pc  = (count_r > HOLD_THRESH);
  assign overflow = overflow_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a reference queue holds the
// expected entries; state and issued entries are compared each cycle.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH       = IFQ_DEPTH;
  localparam int HOLD_MARGIN = IFQ_HOLD_MARGIN;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst1;
  logic [31:0] fetch_inst2;
  logic        fetch_inst2_valid;
  logic [1:0]  issue_cnt;
  logic        out0_valid;
  logic [31:0] out0_pc;
  logic [31:0] out0_inst;
  logic        out1_valid;
  logic [31:0] out1_pc;
  logic [31:0] out1_inst;
  logic        hold_pc;
  logic        overflow;

  inst_fetch_queue #(.DEPTH(DEPTH), .HOLD_MARGIN(HOLD_MARGIN)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_inst1      (fetch_inst1),
    .fetch_inst2      (fetch_inst2),
    .fetch_inst2_valid(fetch_inst2_valid),
    .issue_cnt        (issue_cnt),
    .out0_valid       (out0_valid),
    .out0_pc          (out0_pc),
    .out0_inst        (out0_inst),
    .out1_valid       (out1_valid),
    .out1_pc          (out1_pc),
    .out1_inst        (out1_inst),
    .hold_pc          (hold_pc),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  FetchEntry_t exp_q[$];
  logic        exp_ovf = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        seq_on = 1'b0;
  logic        have_last = 1'b0;
  logic [31:0] last_pc = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs on negedge, check registered state, advance model.
  task automatic tick(input logic r, input logic fl, input logic fv,
                      input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                      input logic i2v, input logic [1:0] ic);
    int sz;
    int lim;
    int rd;
    int wr;
    FetchEntry_t e;
    logic [31:0] got_pc;
    logic [31:0] got_inst;
    @(negedge clk);
    rst = r; flush = fl; fetch_valid = fv; fetch_pc = pc;
    fetch_inst1 = i1; fetch_inst2 = i2; fetch_inst2_valid = i2v; issue_cnt = ic;
    sz = exp_q.size();
    check_val("out0_valid", out0_valid, (sz >= 1));
    check_val("out1_valid", out1_valid, (sz >= 2));
    check_val("out0_pc",   out0_pc,   (sz >= 1) ? exp_q[0].pc   : 32'd0);
    check_val("out0_inst", out0_inst, (sz >= 1) ? exp_q[0].inst : 32'd0);
    check_val("out1_pc",   out1_pc,   (sz >= 2) ? exp_q[1].pc   : 32'd0);
    check_val("out1_inst", out1_inst, (sz >= 2) ? exp_q[1].inst : 32'd0);
    check_val("hold_pc",  hold_pc,  ((DEPTH - sz) < HOLD_MARGIN));
    check_val("overflow", overflow, exp_ovf);
    if (r || fl) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      lim = (ic > 2'd2) ? 2 : int'(ic);
      rd  = (lim < sz) ? lim : sz;
      for (int i = 0; i < rd; i++) begin
        e = exp_q.pop_front();
        got_pc   = (i == 0) ? out0_pc   : out1_pc;
        got_inst = (i == 0) ? out0_inst : out1_inst;
        check_val("issue_pc",   got_pc,   e.pc);
        check_val("issue_inst", got_inst, e.inst);
        if (seq_on && have_last) begin
          check_val("seq_pc", got_pc, last_pc + 32'd4);
        end
        last_pc   = got_pc;
        have_last = 1'b1;
      end
      wr = fv ? (i2v ? 2 : 1) : 0;
      if (sz - rd + wr > DEPTH) begin
        exp_ovf = 1'b1;
      end else begin
        if (wr >= 1) exp_q.push_back('{pc: pc, inst: i1});
        if (wr == 2) exp_q.push_back('{pc: pc + 32'd4, inst: i2});
      end
    end
  endtask

  task automatic idle(input logic [1:0] ic);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, ic);
  endtask

  task automatic pair(input logic [31:0] pc, input logic [1:0] ic);
    tick(1'b0, 1'b0, 1'b1, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0000, 1'b1, ic);
  endtask

  task automatic single(input logic [31:0] pc, input logic [1:0] ic);
    tick(1'b0, 1'b0, 1'b1, pc, pc ^ 32'h1234_0000, 32'hDEAD_BEEF, 1'b0, ic);
  endtask

  logic [31:0] p;

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = 32'd0;
    fetch_inst1 = 32'd0; fetch_inst2 = 32'd0; fetch_inst2_valid = 1'b0; issue_cnt = 2'd0;
    repeat (2) @(posedge clk);

    // First pair after reset, nothing issued.
    tick(1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h2408_0001, 32'h2409_0002, 1'b1, 2'd0);
    idle(2'd2);
    // Single word into an empty queue while decode asks for two.
    single(32'hBFC0_0004, 2'd2);
    idle(2'd0);
    idle(2'd1);

    // Fill with pairs: hold rises at 6, the held pair lands at 8, then a forced write overflows.
    p = 32'h0000_1000;
    for (int i = 0; i < 4; i++) begin
      pair(p, 2'd0);
      p = p + 32'd8;
    end
    pair(p, 2'd0);
    idle(2'd0);
    idle(2'd2);
    tick(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0);

    // Flush racing a write and a read at count 5.
    pair(32'h0000_1100, 2'd0);
    pair(32'h0000_1108, 2'd0);
    single(32'h0000_1110, 2'd0);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_1200, 32'h1, 32'h2, 1'b1, 2'd2);
    idle(2'd0);

    // Full-rate steady state: pointers wrap repeatedly, pc stream contiguous.
    seq_on = 1'b1; have_last = 1'b0;
    p = 32'h0000_2000;
    for (int i = 0; i < 22; i++) begin
      pair(p, (i < 2) ? 2'd0 : 2'd2);
      p = p + 32'd8;
    end
    idle(2'd2);
    idle(2'd2);
    idle(2'd0);
    seq_on = 1'b0;

    // issue_cnt=3 with one entry, then a pair whose second pc wraps to 0.
    single(32'h0000_3000, 2'd0);
    idle(2'd3);
    pair(32'hFFFF_FFFC, 2'd3);
    idle(2'd0);
    idle(2'd3);
    idle(2'd0);

    // Reset in the middle of traffic.
    pair(32'h0000_4000, 2'd0);
    pair(32'h0000_4008, 2'd1);
    tick(1'b1, 1'b0, 1'b1, 32'h0000_4010, 32'h3, 32'h4, 1'b1, 2'd2);
    idle(2'd0);
    pair(32'h0000_5000, 2'd0);
    idle(2'd2);
    idle(2'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
